// File: rtl/sat_window_accumulator_pkg.sv
// Shared FSM state type and clamp-constant helpers for the saturating window accumulator
// and any other datapath block that reuses sat_add_core.
package sat_acc_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } acc_state_e;

  // Largest positive two's-complement value representable in 'width' bits.
  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Most negative two's-complement value representable in 'width' bits.
  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/sat_window_accumulator_if.sv
// Sample-in / result-out handshake bundle for sat_window_accumulator.
// master = producer/consumer side, slave = the accumulator.
interface sat_window_accumulator_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_overflow;
  logic                  out_underflow;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_overflow, out_underflow, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_overflow, out_underflow, out_valid
  );
endinterface

// File: rtl/sat_window_accumulator_sat_add_core.sv
// sat_add_core: combinational two's-complement adder that clamps to max positive / max
// negative and reports which way it clamped.
module sat_add_core
  import sat_acc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic             unf
);
  localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MAX_NEG = WIDTH'(sat_min(WIDTH));

  logic [WIDTH-1:0] raw;

  always_comb begin
    raw = a + b;
    // Overflow is only possible when both operands share a sign and the result flips it.
    ovf = ~a[WIDTH-1] & ~b[WIDTH-1] &  raw[WIDTH-1];
    unf =  a[WIDTH-1] &  b[WIDTH-1] & ~raw[WIDTH-1];
    sum = ovf ? MAX_POS : (unf ? MAX_NEG : raw);
  end
endmodule

// File: rtl/sat_window_accumulator.sv
// sat_window_accumulator: sums 2^LOG2_TERMS signed samples with saturation and emits one
// result plus sticky overflow/underflow per window. Define SAT_WINDOW_ACC_MEAN_EN to emit
// the rounded mean instead of the sum.
module sat_window_accumulator
  import sat_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PNT  = 8,
  parameter int LOG2_TERMS = 2
) (
  input logic                        clk,
  input logic                        rst,
  input logic                        clear,
  sat_window_accumulator_if.slave    bus
);
  localparam int NUM_TERMS = 1 << LOG2_TERMS;
  localparam int CNT_W     = (LOG2_TERMS > 0) ? LOG2_TERMS : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  acc_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_ovf_q, out_ovf_d;
  logic                  out_unf_q, out_unf_d;

  logic [DATA_WIDTH-1:0] acc_next;
  logic                  add_ovf, add_unf;
  logic [DATA_WIDTH-1:0] result;

  sat_add_core #(.WIDTH(DATA_WIDTH)) u_add (
    .a   (acc_q),
    .b   (bus.in_data),
    .sum (acc_next),
    .ovf (add_ovf),
    .unf (add_unf)
  );

`ifdef SAT_WINDOW_ACC_MEAN_EN
  // One extra bit of headroom so the rounding bias cannot wrap near max positive.
  localparam logic signed [DATA_WIDTH:0] ROUND_BIAS = (DATA_WIDTH + 1)'(NUM_TERMS / 2);
  logic signed [DATA_WIDTH:0] mean_wide;
  assign mean_wide = ($signed({acc_next[DATA_WIDTH-1], acc_next}) + ROUND_BIAS) >>> LOG2_TERMS;
  assign result    = mean_wide[DATA_WIDTH-1:0];
`else
  assign result = acc_next;
`endif

  assign bus.in_ready      = (state_q == ACCUM);
  assign bus.out_valid     = (state_q == OUTPUT);
  assign bus.out_data      = out_data_q;
  assign bus.out_overflow  = out_ovf_q;
  assign bus.out_underflow = out_unf_q;

  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a variable unassigned (no latches).
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    out_unf_d  = out_unf_q;

    if (clear) begin
      // Result registers may stay stale; they are invisible while out_valid is low.
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.in_valid) begin
            if (cnt_q == LAST_CNT) begin
              out_data_d = result;
              out_ovf_d  = ovf_q | add_ovf;
              out_unf_d  = unf_q | add_unf;
              state_d    = OUTPUT;
              acc_d      = '0;
              cnt_d      = '0;
              ovf_d      = 1'b0;
              unf_d      = 1'b0;
            end else begin
              acc_d = acc_next;
              cnt_d = cnt_q + CNT_W'(1);
              ovf_d = ovf_q | add_ovf;
              unf_d = unf_q | add_unf;
            end
          end
        end
        OUTPUT: begin
          if (bus.out_ready) state_d = ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
    if (rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      out_unf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      out_unf_q  <= out_unf_d;
    end
  end
endmodule
